// File: rtl/psram_cmd_pkg.sv
// Shared types and constants for the UART-to-PSRAM command sequencer.
package psram_cmd_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  localparam logic [7:0] OP_RD       = 8'h00;
  localparam logic [7:0] OP_WR       = 8'h01;
  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_DEFAULT = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_ISSUE,
    S_WAIT,
    S_TX0,
    S_TX1
  } seq_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } psram_req_t;

endpackage

// File: rtl/psram_cmd_sequencer.sv
// Parses UART command bytes, runs one PSRAM read/write, and answers over UART TX.
// Inter-byte and PSRAM-completion timeouts keep a broken peer from wedging the link.
module psram_cmd_sequencer
  import psram_cmd_pkg::*;
#(
  parameter int unsigned GAP_CYC  = 10_000,
  parameter int unsigned DONE_CYC = 1_000,
  parameter logic [7:0]  ACK_BYTE = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        err_gap
);

  localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);
  localparam int unsigned DONE_W = $clog2(DONE_CYC + 1);

  seq_state_t        r_state, w_state_nxt;
  logic [1:0]        r_cnt, w_cnt_nxt;
  psram_req_t        r_req, w_req_nxt;
  logic [15:0]       r_rdata, w_rdata_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_tx_valid, w_tx_valid_nxt;
  logic [7:0]        r_tx_data, w_tx_data_nxt;
  logic              r_err_gap, w_err_gap_nxt;
  logic              r_busy;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [DONE_W-1:0] r_done_cnt;

  logic w_rx_state;
  logic w_gap_to;
  logic w_done_to;

  assign w_rx_state = (r_state == S_ADDR) || (r_state == S_WDATA);
  assign w_gap_to   = w_rx_state && (r_gap_cnt == GAP_W'(GAP_CYC));
  assign w_done_to  = (r_state == S_WAIT) && (r_done_cnt == DONE_W'(DONE_CYC));

  // Inter-byte gap timer, live only while a command is being received.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_gap_cnt <= '0;
    end else if (!w_rx_state || rx_valid) begin
      r_gap_cnt <= '0;
    end else if (!w_gap_to) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

  // PSRAM completion timer, live only in WAIT.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_done_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_done_cnt <= '0;
    end else if (!w_done_to) begin
      r_done_cnt <= r_done_cnt + DONE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_req      <= '0;
      r_rdata    <= '0;
      r_mem_req  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_err_gap  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_req      <= w_req_nxt;
      r_rdata    <= w_rdata_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_err_gap  <= w_err_gap_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_req_nxt      = r_req;
    w_rdata_nxt    = r_rdata;
    w_mem_req_nxt  = r_mem_req;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    w_err_gap_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if ((rx_data == OP_RD) || (rx_data == OP_WR)) begin
            w_req_nxt.we = rx_data[0];
            w_cnt_nxt    = '0;
            w_state_nxt  = S_ADDR;
          end else begin
            w_tx_valid_nxt = 1'b1;
            w_tx_data_nxt  = NAK_BYTE;
            w_state_nxt    = S_TX1;
          end
        end
      end

      // A gap timeout takes priority over a byte arriving on the same cycle.
      S_ADDR: begin
        if (w_gap_to) begin
          w_err_gap_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else if (rx_valid) begin
          case (r_cnt)
            2'd0:    w_req_nxt.addr[7:0]   = rx_data;
            2'd1:    w_req_nxt.addr[15:8]  = rx_data;
            default: w_req_nxt.addr[23:16] = rx_data;
          endcase
          if (r_cnt == 2'd2) begin
            w_cnt_nxt = '0;
            if (r_req.we) begin
              w_state_nxt = S_WDATA;
            end else begin
              w_mem_req_nxt = 1'b1;
              w_state_nxt   = S_ISSUE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end

      S_WDATA: begin
        if (w_gap_to) begin
          w_err_gap_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else if (rx_valid) begin
          if (r_cnt == 2'd0) begin
            w_req_nxt.wdata[7:0] = rx_data;
            w_cnt_nxt            = 2'd1;
          end else begin
            w_req_nxt.wdata[15:8] = rx_data;
            w_cnt_nxt             = '0;
            w_mem_req_nxt         = 1'b1;
            w_state_nxt           = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (r_mem_req && mem_ready) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_done) begin
          w_tx_valid_nxt = 1'b1;
          if (r_req.we) begin
            w_tx_data_nxt = ACK_BYTE;
            w_state_nxt   = S_TX1;
          end else begin
            w_rdata_nxt   = mem_rdata;
            w_tx_data_nxt = mem_rdata[7:0];
            w_state_nxt   = S_TX0;
          end
        end else if (w_done_to) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = NAK_BYTE;
          w_state_nxt    = S_TX1;
        end
      end

      S_TX0: begin
        if (r_tx_valid && tx_ready) begin
          w_tx_data_nxt = r_rdata[15:8];
          w_state_nxt   = S_TX1;
        end
      end

      S_TX1: begin
        if (r_tx_valid && tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_req.we;
  assign mem_addr  = r_req.addr;
  assign mem_wdata = r_req.wdata;
  assign busy      = r_busy;
  assign err_gap   = r_err_gap;

endmodule

// File: tb/tb_psram_cmd_sequencer.sv
// Directed bench for psram_cmd_sequencer: command table plus hand-written corner sequences.
module tb_psram_cmd_sequencer;

  localparam int unsigned GAP_CYC  = 40;
  localparam int unsigned DONE_CYC = 30;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        mem_req;
  logic        mem_ready = 1'b1;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        busy;
  logic        err_gap;

  always #5 clk = ~clk;

  psram_cmd_sequencer #(
    .GAP_CYC  (GAP_CYC),
    .DONE_CYC (DONE_CYC),
    .ACK_BYTE (8'h06),
    .NAK_BYTE (8'h15)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .mem_req   (mem_req),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err_gap   (err_gap)
  );

  typedef struct {
    logic [47:0] bytes;
    int          nb;
    int          done_dly;
    logic [15:0] rdata;
    logic        exp_mem;
    logic        exp_we;
    logic [23:0] exp_addr;
    logic [15:0] exp_wdata;
    int          exp_ntx;
    logic [15:0] exp_tx;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int          n_hs = 0;
  int          n_gap = 0;
  logic        cap_we = 1'b0;
  logic [23:0] cap_addr = '0;
  logic [15:0] cap_wdata = '0;
  logic [7:0]  tx_q[$];

  // Handshake monitor; inputs only change just after posedge, so negedge sees what the edge will see.
  always @(negedge clk) begin
    if (mem_req && mem_ready) begin
      n_hs      = n_hs + 1;
      cap_we    = mem_we;
      cap_addr  = mem_addr;
      cap_wdata = mem_wdata;
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (err_gap) n_gap = n_gap + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_hs(input int base, output bit ok);
    int k = 0;
    while (n_hs == base && k < 200) begin
      step();
      k++;
    end
    ok = (n_hs != base);
  endtask

  task automatic wait_idle(output bit ok);
    int k = 0;
    while (busy && k < 500) begin
      step();
      k++;
    end
    ok = !busy;
  endtask

  task automatic pulse_done(input logic [15:0] rd);
    mem_done  = 1'b1;
    mem_rdata = rd;
    step();
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  function automatic vec_t mk(input logic [47:0] bytes, input int nb, input int dly,
                              input logic [15:0] rd, input logic em, input logic we,
                              input logic [23:0] addr, input logic [15:0] wd,
                              input int ntx, input logic [15:0] tx);
    vec_t v;
    v.bytes = bytes; v.nb = nb; v.done_dly = dly; v.rdata = rd;
    v.exp_mem = em; v.exp_we = we; v.exp_addr = addr; v.exp_wdata = wd;
    v.exp_ntx = ntx; v.exp_tx = tx;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int hb = n_hs;
    int tb = tx_q.size();
    bit ok;
    for (int i = 0; i < v.nb; i++) send_byte(v.bytes[8*i +: 8]);
    if (v.exp_mem) begin
      wait_hs(hb, ok);
      check({tag, "_hs_seen"}, 32'(ok), 32'd1);
      repeat (v.done_dly) step();
      pulse_done(v.rdata);
    end
    wait_idle(ok);
    check({tag, "_idle"}, 32'(ok), 32'd1);
    check({tag, "_n_req"}, 32'(n_hs - hb), 32'(v.exp_mem));
    if (v.exp_mem) begin
      check({tag, "_we"}, 32'(cap_we), 32'(v.exp_we));
      check({tag, "_addr"}, 32'(cap_addr), 32'(v.exp_addr));
      if (v.exp_we) check({tag, "_wdata"}, 32'(cap_wdata), 32'(v.exp_wdata));
    end
    check({tag, "_ntx"}, 32'(tx_q.size() - tb), 32'(v.exp_ntx));
    for (int j = 0; j < v.exp_ntx && (tb + j) < tx_q.size(); j++)
      check($sformatf("%s_tx%0d", tag, j), 32'(tx_q[tb + j]), 32'(v.exp_tx[8*j +: 8]));
  endtask

  vec_t vecs[7];

  initial begin
    int  hb;
    int  tb;
    int  gb;
    int  viol;
    int  n;
    bit  ok;

    vecs[0] = mk(48'h0708_0403_0201, 6, 5, 16'h0000, 1'b1, 1'b1, 24'h040302, 16'h0708, 1, 16'h0006);
    vecs[1] = mk(48'h0000_0403_0200, 4, 3, 16'h0708, 1'b1, 1'b0, 24'h040302, 16'h0000, 2, 16'h0708);
    vecs[2] = mk(48'h0000_0000_005A, 1, 0, 16'h0000, 1'b0, 1'b0, 24'h000000, 16'h0000, 1, 16'h0015);
    vecs[3] = mk(48'h0000_CCBB_AA00, 4, 0, 16'hBEEF, 1'b1, 1'b0, 24'hCCBBAA, 16'h0000, 2, 16'hBEEF);
    vecs[4] = mk(48'h1234_FFFF_FF01, 6, 1, 16'h0000, 1'b1, 1'b1, 24'hFFFFFF, 16'h1234, 1, 16'h0006);
    vecs[5] = mk(48'h0000_0000_1000, 4, 2, 16'h0000, 1'b1, 1'b0, 24'h000010, 16'h0000, 2, 16'h0000);
    vecs[6] = mk(48'h0000_0000_0002, 1, 0, 16'h0000, 1'b0, 1'b0, 24'h000000, 16'h0000, 1, 16'h0015);

    // Reset values.
    step();
    step();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_fields", 32'({mem_we, mem_addr}), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_gap", 32'(err_gap), 32'd0);
    arst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure on both the PSRAM request and the TX byte.
    hb = n_hs;
    tb = tx_q.size();
    mem_ready = 1'b0;
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    viol = 0;
    repeat (50) begin
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 24'h332211) viol++;
      step();
    end
    check("bp_req_stable", 32'(viol), 32'd0);
    check("bp_no_accept", 32'(n_hs - hb), 32'd0);
    tx_ready  = 1'b0;
    mem_ready = 1'b1;
    wait_hs(hb, ok);
    check("bp_hs_seen", 32'(ok), 32'd1);
    check("bp_req_drop", 32'(mem_req), 32'd0);
    repeat (2) step();
    pulse_done(16'hA55A);
    viol = 0;
    repeat (30) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h5A) viol++;
      step();
    end
    check("bp_tx_stable", 32'(viol), 32'd0);
    check("bp_tx_held", 32'(tx_q.size() - tb), 32'd0);
    tx_ready = 1'b1;
    wait_idle(ok);
    check("bp_idle", 32'(ok), 32'd1);
    check("bp_ntx", 32'(tx_q.size() - tb), 32'd2);
    if (tx_q.size() >= tb + 2) begin
      check("bp_tx0", 32'(tx_q[tb]), 32'h5A);
      check("bp_tx1", 32'(tx_q[tb + 1]), 32'hA5);
    end
    check("bp_n_req", 32'(n_hs - hb), 32'd1);

    // Gap timer: last-moment byte accepted, byte colliding with the timeout dropped.
    hb = n_hs;
    tb = tx_q.size();
    gb = n_gap;
    send_byte(8'h01); send_byte(8'h02);
    repeat (GAP_CYC - 1) step();
    send_byte(8'h03);
    repeat (GAP_CYC) step();
    check("gap_no_early", 32'(n_gap - gb), 32'd0);
    check("gap_busy_before", 32'(busy), 32'd1);
    send_byte(8'h05);
    repeat (GAP_CYC + 5) step();
    check("gap_pulses", 32'(n_gap - gb), 32'd1);
    check("gap_idle", 32'(busy), 32'd0);
    check("gap_no_req", 32'(n_hs - hb), 32'd0);
    check("gap_no_tx", 32'(tx_q.size() - tb), 32'd0);
    run_vec(mk(48'h0E0D_0C0B_0A01, 6, 2, 16'h0000, 1'b1, 1'b1, 24'h0C0B0A, 16'h0E0D, 1, 16'h0006),
            "gap_next");

    // Hung PSRAM: NAK after the completion timeout, late mem_done ignored.
    hb = n_hs;
    tb = tx_q.size();
    tx_ready = 1'b0;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    wait_hs(hb, ok);
    check("hung_hs_seen", 32'(ok), 32'd1);
    n = 0;
    while (!tx_valid && n < int'(DONE_CYC) + 20) begin
      step();
      n++;
    end
    check("hung_latency", 32'(n), 32'(DONE_CYC + 1));
    check("hung_nak_data", 32'(tx_data), 32'h15);
    tx_ready = 1'b1;
    wait_idle(ok);
    check("hung_idle", 32'(ok), 32'd1);
    check("hung_ntx", 32'(tx_q.size() - tb), 32'd1);
    if (tx_q.size() > tb) check("hung_nak", 32'(tx_q[tb]), 32'h15);
    tb = tx_q.size();
    pulse_done(16'h1234);
    repeat (3) step();
    check("late_done_busy", 32'(busy), 32'd0);
    check("late_done_tx", 32'(tx_q.size() - tb), 32'd0);

    // Asynchronous reset while a read response sits in TX0.
    hb = n_hs;
    tx_ready = 1'b0;
    send_byte(8'h00); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    wait_hs(hb, ok);
    check("rst_tx0_hs", 32'(ok), 32'd1);
    pulse_done(16'h9988);
    check("rst_tx0_valid", 32'(tx_valid), 32'd1);
    check("rst_tx0_data", 32'(tx_data), 32'h88);
    #2;
    arst = 1'b1;
    #1;
    check("arst_tx_valid", 32'(tx_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    #1;
    arst = 1'b0;
    tx_ready = 1'b1;
    step();
    run_vec(vecs[1], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
